instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Byte-addressed instruction memory for the 16-bit CPU fetch stage.
- Takes the 16-bit PC and returns the 16-bit instruction stored big-endian in bytes PC and PC+1.
- Output is registered: one clock of latency after PC is presented.
- Contents come from a fixed boot image restored on reset; an optional load port allows runtime programming.

Parameters:
- MEM_BYTES, 256, number of byte locations implemented (power of two, 2..65536).
- ADDR_W, 16, PC/address width.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- PC  input  16  byte address of the instruction to fetch.
- Instruction  output  16  fetched instruction word, registered.

Behaviour:
- Storage: MEM_BYTES x 8-bit array.
- Fetch: on each rising Clock, Instruction <= {mem[PC], mem[PC+1]}. Byte at PC is bits 15:8; byte at PC+1 is bits 7:0.
- Latency: PC sampled at edge N appears on Instruction after edge N, and holds until the next edge.
- Unaligned access: any PC is legal, including odd values. There is no alignment check and no fault.
- PC+1 is computed in ADDR_W bits: PC=0xFFFF gives second byte address 0x0000 (wrap).
- Out-of-range bytes (address >= MEM_BYTES) read as 0x00. Each byte of the pair is checked independently.
  - Example, MEM_BYTES=256: PC=0x00FF returns {mem[255], 0x00}.
  - Example: PC=0x0100 returns 0x0000.
- Reset (Reset_n=0, asynchronous):
  - Instruction forced to 0x0000 immediately.
  - Array restored to the boot image.
  - Held while Reset_n is low.
- First fetch after reset release happens at the first rising edge with Reset_n=1.
- Boot image, bytes 0x00..0x0B: 00 12 34 56 78 9A BC DE F0 11 22 33. All other bytes are 0x00.
- Reset asserted mid-operation: any pending output update is discarded. Instruction reads 0x0000 until the first post-release edge.

Optional Feature:
- Macro: IMEM_LOAD_EN.
- With the macro defined, add three inputs:
  - LoadEn, 1 bit.
  - LoadAddr, 16 bits.
  - LoadData, 8 bits.
- Load write: on a rising edge with LoadEn=1 and LoadAddr < MEM_BYTES, mem[LoadAddr] <= LoadData. Writes to out-of-range addresses are ignored.
- Write and fetch to the same byte on the same edge: the fetch returns the old byte (read-before-write). The new byte is visible from the next edge.
- Reset overrides any in-progress loads and restores the boot image.
- Without the macro: the load ports do not exist, the array is constant (boot image only), and it synthesizes as ROM.

Decomposition:
- Package imem_pkg holds:
  - MEM_BYTES default.
  - NOP word constant 16'h0000.
  - BOOT_IMAGE byte constant/function used for reset contents.
- Sub-module imem_byte_array: byte storage, boot-image reset, and optional write port.
- The top level handles address bounds/wrap, big-endian word assembly, and the output register.

Test Plan:
- Reset: hold Reset_n=0 with PC=9 -> Instruction=0x0000. Release, then one edge -> Instruction=0x1122.
- Aligned and unaligned fetch: PC=0 -> 0x0012 after one edge; PC=1 -> 0x1234; PC=10 -> 0x2233; PC=11 -> 0x3300.
- Latency: change PC every cycle 0,2,4 -> outputs 0x0012, 0x3456, 0x789A, each one edge after its PC.
- Bounds and wrap (MEM_BYTES=256): PC=0x00FF -> 0x0000 (image zero). PC=0xFFFF -> {0x00, mem[0]=0x00} = 0x0000. Repeat with MEM_BYTES=65536 and mem[0] preloaded via the load port -> low byte equals mem[0].
- IMEM_LOAD_EN: write 0xAB to addr 20 and 0xCD to addr 21, then PC=20 -> 0xABCD. Write addr 9 and fetch PC=9 on the same edge -> old 0x1122, then new value on the next edge.
- Mid-operation reset: after loading addr 20, pulse Reset_n low between edges -> Instruction drops to 0x0000 immediately. After release, PC=20 -> 0x0000 (image restored).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory: default geometry, the NOP word
// and the boot image restored on reset.
package imem_pkg;

  localparam int MEM_BYTES_DEF = 256;
  localparam int ADDR_W_DEF    = 16;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  // Boot image contents; every byte past 0x0B is zero.
  function automatic logic [7:0] boot_byte(input int unsigned addr);
    logic [7:0] b;
    case (addr)
      0:       b = 8'h00;
      1:       b = 8'h12;
      2:       b = 8'h34;
      3:       b = 8'h56;
      4:       b = 8'h78;
      5:       b = 8'h9A;
      6:       b = 8'hBC;
      7:       b = 8'hDE;
      8:       b = 8'hF0;
      9:       b = 8'h11;
      10:      b = 8'h22;
      11:      b = 8'h33;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch bus between the CPU fetch stage (master) and the instruction memory
// (slave). The runtime load port exists only when IMEM_LOAD_EN is defined.
interface imem_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] PC;
  logic [15:0]       Instruction;
`ifdef IMEM_LOAD_EN
  logic              LoadEn;
  logic [15:0]       LoadAddr;
  logic [7:0]        LoadData;

  modport master (output PC, input Instruction, output LoadEn, output LoadAddr, output LoadData);
  modport slave  (input PC, output Instruction, input LoadEn, input LoadAddr, input LoadData);
`else
  modport master (output PC, input Instruction);
  modport slave  (input PC, output Instruction);
`endif
endinterface

// File: rtl/imem_byte_array.sv
// Byte storage for the instruction memory with two combinational read ports.
// IMEM_LOAD_EN defined: a writable array restored to the boot image on reset.
// IMEM_LOAD_EN undefined: the boot image only, a pure ROM with no clock.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int AW        = $clog2(MEM_BYTES)
) (
`ifdef IMEM_LOAD_EN
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
`endif
  input  logic [AW-1:0] rd_addr_a_i,
  output logic [7:0]    rd_data_a_o,
  input  logic [AW-1:0] rd_addr_b_i,
  output logic [7:0]    rd_data_b_o
);

`ifdef IMEM_LOAD_EN
  logic [7:0] mem_q [MEM_BYTES];

  // Reset restores the boot image; otherwise apply the one-byte load write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= boot_byte(i);
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Reads see the array before any write on the same edge.
  assign rd_data_a_o = mem_q[rd_addr_a_i];
  assign rd_data_b_o = mem_q[rd_addr_b_i];
`else
  assign rd_data_a_o = boot_byte(32'(rd_addr_a_i));
  assign rd_data_b_o = boot_byte(32'(rd_addr_b_i));
`endif

endmodule

// File: rtl/instruction_memory.sv
// Byte-addressed instruction memory: returns {mem[PC], mem[PC+1]} one clock
// after PC is presented. PC+1 wraps in ADDR_W bits and each byte beyond
// MEM_BYTES reads as zero. Define IMEM_LOAD_EN to add the runtime load port.
module instruction_memory
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic  Clock,
  input  logic  Reset_n,
  imem_if.slave bus
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [ADDR_W-1:0] addr_hi;
  logic [ADDR_W-1:0] addr_lo;
  logic              in_hi;
  logic              in_lo;
  logic [7:0]        byte_hi;
  logic [7:0]        byte_lo;
  logic [15:0]       instr_d;
  logic [15:0]       instr_q;

  // Byte pair addresses with ADDR_W wrap and per-byte bounds check.
  always_comb begin
    addr_hi = bus.PC;
    addr_lo = bus.PC + ADDR_W'(1);
    in_hi   = 32'(addr_hi) < 32'(MEM_BYTES);
    in_lo   = 32'(addr_lo) < 32'(MEM_BYTES);
  end

`ifdef IMEM_LOAD_EN
  logic wr_en;
  assign wr_en = bus.LoadEn && (32'(bus.LoadAddr) < 32'(MEM_BYTES));
`endif

  imem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
`ifdef IMEM_LOAD_EN
    .clk_i       (Clock),
    .rst_n_i     (Reset_n),
    .wr_en_i     (wr_en),
    .wr_addr_i   (bus.LoadAddr[AW-1:0]),
    .wr_data_i   (bus.LoadData),
`endif
    .rd_addr_a_i (addr_hi[AW-1:0]),
    .rd_data_a_o (byte_hi),
    .rd_addr_b_i (addr_lo[AW-1:0]),
    .rd_data_b_o (byte_lo)
  );

  // Big-endian word assembly: byte at PC in the upper half.
  always_comb begin
    instr_d = {(in_hi ? byte_hi : 8'h00), (in_lo ? byte_lo : 8'h00)};
  end

  // Output register; reset forces the NOP word immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_q <= NOP_WORD;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign bus.Instruction = instr_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: a 256-byte and a 65536-byte
// instance see the same PC stream; expectations are queued per edge and a
// monitor compares one edge later. Load-port vectors run with IMEM_LOAD_EN.
module tb_instruction_memory;

  logic Clock;
  logic Reset_n;

  imem_if #(.ADDR_W(16)) ifa ();
  imem_if #(.ADDR_W(16)) ifb ();

  instruction_memory #(.MEM_BYTES(256), .ADDR_W(16)) dut_a (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (ifa.slave)
  );

  instruction_memory #(.MEM_BYTES(65536), .ADDR_W(16)) dut_b (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (ifb.slave)
  );

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

`ifdef IMEM_LOAD_EN
  logic        nx_en;
  logic [15:0] nx_addr;
  logic [7:0]  nx_data;
`endif

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present PC (and any pending load) at the falling edge; queue the words
  // expected after the next rising edge.
  task automatic cycle(input logic [15:0] pc, input logic [15:0] ea, input logic [15:0] eb);
    @(negedge Clock);
    ifa.PC = pc;
    ifb.PC = pc;
`ifdef IMEM_LOAD_EN
    ifa.LoadEn   = nx_en;
    ifa.LoadAddr = nx_addr;
    ifa.LoadData = nx_data;
    ifb.LoadEn   = nx_en;
    ifb.LoadAddr = nx_addr;
    ifb.LoadData = nx_data;
    nx_en = 1'b0;
`endif
    q.push_back('{ea, eb});
  endtask

`ifdef IMEM_LOAD_EN
  task automatic load(input logic [15:0] a, input logic [7:0] d);
    nx_en   = 1'b1;
    nx_addr = a;
    nx_data = d;
  endtask
`endif

  // Asynchronous reset pulse between edges, after the last fetch was checked.
  task automatic reset_pulse();
    @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("midrst_a", ifa.Instruction, 16'h0000);
    chk("midrst_b", ifb.Instruction, 16'h0000);
    #1;
    Reset_n = 1'b1;
  endtask

  // Monitor: one queued expectation per rising edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (Reset_n && q.size() > 0) begin
        e = q.pop_front();
        chk("fetch_a", ifa.Instruction, e.ea);
        chk("fetch_b", ifb.Instruction, e.eb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    Reset_n = 1'b1;
    ifa.PC  = 16'd9;
    ifb.PC  = 16'd9;
`ifdef IMEM_LOAD_EN
    nx_en = 1'b0; nx_addr = '0; nx_data = '0;
    ifa.LoadEn = 1'b0; ifa.LoadAddr = '0; ifa.LoadData = '0;
    ifb.LoadEn = 1'b0; ifb.LoadAddr = '0; ifb.LoadData = '0;
`endif
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_a", ifa.Instruction, 16'h0000);
    chk("rst_b", ifb.Instruction, 16'h0000);
    repeat (2) @(negedge Clock);
    chk("rst_hold_a", ifa.Instruction, 16'h0000);
    chk("rst_hold_b", ifb.Instruction, 16'h0000);

    // Release with PC=9: first fetch on the first edge with Reset_n high.
    @(negedge Clock);
    Reset_n = 1'b1;
    q.push_back('{16'h1122, 16'h1122});

    // Aligned / unaligned fetch.
    cycle(16'd0,  16'h0012, 16'h0012);
    cycle(16'd1,  16'h1234, 16'h1234);
    cycle(16'd10, 16'h2233, 16'h2233);
    cycle(16'd11, 16'h3300, 16'h3300);
    // Back-to-back PC changes.
    cycle(16'd0,  16'h0012, 16'h0012);
    cycle(16'd2,  16'h3456, 16'h3456);
    cycle(16'd4,  16'h789A, 16'h789A);
    // Bounds and wrap against the boot image.
    cycle(16'h00FF, 16'h0000, 16'h0000);
    cycle(16'hFFFF, 16'h0000, 16'h0000);
    cycle(16'h0100, 16'h0000, 16'h0000);
    cycle(16'd7,    16'hDEF0, 16'hDEF0);

`ifdef IMEM_LOAD_EN
    load(16'd20, 8'hAB); cycle(16'd9, 16'h1122, 16'h1122);
    load(16'd21, 8'hCD); cycle(16'd9, 16'h1122, 16'h1122);
    cycle(16'd20, 16'hABCD, 16'hABCD);
    // Same-edge write and fetch: old byte first, new byte next edge.
    load(16'd9, 8'h55);  cycle(16'd9, 16'h1122, 16'h1122);
    cycle(16'd9, 16'h5522, 16'h5522);
    // Boundary loads: 0x100 and 0xFFFF exist only in the 64K instance.
    load(16'h00FF, 8'h77); cycle(16'd0, 16'h0012, 16'h0012);
    load(16'h0100, 8'h66); cycle(16'd0, 16'h0012, 16'h0012);
    load(16'h0000, 8'h5A); cycle(16'h00FF, 16'h7700, 16'h7766);
    load(16'hFFFF, 8'h99); cycle(16'd0, 16'h5A12, 16'h5A12);
    cycle(16'hFFFF, 16'h005A, 16'h995A);
    cycle(16'h0100, 16'h0000, 16'h6600);
    cycle(16'd20,   16'hABCD, 16'hABCD);
`endif

    // Mid-operation reset: output drops at once, image restored.
    reset_pulse();
    cycle(16'd20, 16'h0000, 16'h0000);
    cycle(16'd9,  16'h1122, 16'h1122);
    cycle(16'd0,  16'h0012, 16'h0012);
    cycle(16'h00FF, 16'h0000, 16'h0000);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clock);
    #2;
    chk("drain", 16'(q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
